// File: rtl/cpu7_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu7_prog_loader: UART (8N1) framed program-image loader for cpu7_soc.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu7_prog_loader #(
  parameter int CLOCK_FREQ_MHZ = 1,
  parameter int BAUD_RATE      = 100000,
  parameter int PROGRAM_SIZE   = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  output logic                            mem_we,
  output logic [$clog2(PROGRAM_SIZE)-1:0] mem_addr,
  output logic [7:0]                      mem_wdata,
  output logic                            cpu_hold,
  output logic                            done,
  output logic                            err
);

  localparam int AW           = $clog2(PROGRAM_SIZE);
  localparam int CLKS_PER_BIT = CLOCK_FREQ_MHZ * 1000000 / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]   PROG_SIZE_EXT = 17'(PROGRAM_SIZE);
  localparam logic [7:0]    SYNC_BYTE     = 8'hA5;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LD_IDLE   = 3'd0;
  localparam logic [2:0] LD_LEN_HI = 3'd1;
  localparam logic [2:0] LD_LEN_LO = 3'd2;
  localparam logic [2:0] LD_DATA   = 3'd3;
  localparam logic [2:0] LD_CSUM   = 3'd4;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          byte_valid, frame_err;

  logic [2:0]    ld_state_q, ld_state_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [15:0]   len_q, len_d;
  logic [AW-1:0] count_q, count_d;
  logic [7:0]    acc_q, acc_d;
  logic [15:0]   frame_len;

  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // The idle-high reset value of the synchroniser keeps reset release from
  // looking like a start-bit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign frame_len = {len_hi_q, rx_shift_q};

  always_comb begin
    ld_state_d  = ld_state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    count_d     = count_q;
    acc_d       = acc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = 1'b0;
    err_d       = err_q;
    if (frame_err && (ld_state_q != LD_IDLE)) begin
      err_d      = 1'b1;
      ld_state_d = LD_IDLE;
    end else if (byte_valid) begin
      case (ld_state_q)
        LD_IDLE: begin
          if (rx_shift_q == SYNC_BYTE) begin
            err_d      = 1'b0;
            cpu_hold_d = 1'b1;
            ld_state_d = LD_LEN_HI;
          end
        end
        LD_LEN_HI: begin
          len_hi_d   = rx_shift_q;
          ld_state_d = LD_LEN_LO;
        end
        LD_LEN_LO: begin
          len_d   = frame_len;
          count_d = '0;
          acc_d   = '0;
          if ({1'b0, frame_len} > PROG_SIZE_EXT) begin
            err_d      = 1'b1;
            ld_state_d = LD_IDLE;
          end else if (frame_len == 16'd0) begin
            ld_state_d = LD_CSUM;
          end else begin
            ld_state_d = LD_DATA;
          end
        end
        LD_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q;
          mem_wdata_d = rx_shift_q;
          acc_d       = acc_q + rx_shift_q;
          // The counter holds on the last byte so it never wraps at full depth.
          if (16'(count_q) == len_q - 16'd1) begin
            ld_state_d = LD_CSUM;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        LD_CSUM: begin
          if (rx_shift_q == acc_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          ld_state_d = LD_IDLE;
        end
        default: ld_state_d = LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q  <= LD_IDLE;
      len_hi_q    <= '0;
      len_q       <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ld_state_q  <= ld_state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu7_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu7_prog_loader: drives UART frames, checks against a frame-level model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cpu7_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;

  cpu7_prog_loader #(
    .CLOCK_FREQ_MHZ(1),
    .BAUD_RATE(100000),
    .PROGRAM_SIZE(1024)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  frame[$];
  logic [17:0] exp_w[$];
  logic [17:0] got_w[$];
  int          done_cnt = 0;
  int          exp_done = 0;
  bit          m_hold = 1'b0;
  bit          m_err = 1'b0;
  bit          hold_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) got_w.push_back({mem_addr, mem_wdata});
      if (done) done_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (10) @(negedge clk);
    rx = 1'b1;
  endtask

  // Frame-level reference: parse the byte list by the framing rules.
  task automatic model_frame();
    int unsigned n;
    int unsigned sum;
    exp_w.delete();
    exp_done = 0;
    if (frame.size() == 0 || frame[0] != 8'hA5) return;
    m_hold = 1'b1;
    m_err  = 1'b0;
    if (frame.size() < 3) return;
    n = {16'd0, frame[1], frame[2]};
    if (n > 1024) begin
      m_err = 1'b1;
      return;
    end
    sum = 0;
    for (int i = 0; i < int'(n) && (3 + i) < frame.size(); i++) begin
      exp_w.push_back({10'(i), frame[3+i]});
      sum = sum + frame[3+i];
    end
    if (frame.size() > 3 + n) begin
      if (frame[3+n] == sum[7:0]) begin
        exp_done = 1;
        m_hold   = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic send_frame();
    got_w.delete();
    done_cnt = 0;
    model_frame();
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], 1'b0);
      if (i == 0) hold_seen = cpu_hold;
    end
    repeat (20) @(negedge clk);
  endtask

  function automatic bit writes_match();
    if (got_w.size() != exp_w.size()) return 1'b0;
    for (int i = 0; i < got_w.size(); i++)
      if (got_w[i] !== exp_w[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    bit quiet;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== 22'd0) begin
      bad++;
      $display("FAIL reset_values got=%h want=0", {mem_we, mem_addr, mem_wdata, cpu_hold, done, err});
    end
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== 22'd0) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL idle_quiet got=%0d want=1", quiet);
    end
    frame = '{8'h3C};
    send_frame();
    total++;
    if (got_w.size() != 0 || done_cnt != 0 || {cpu_hold, err} !== 2'b00) begin
      bad++;
      $display("FAIL non_sync_ignored writes=%0d done=%0d hold=%0d err=%0d want 0/0/0/0",
               got_w.size(), done_cnt, cpu_hold, err);
    end
  endtask

  task automatic test_basic();
    frame = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_frame();
    total++;
    if (hold_seen !== 1'b1) begin
      bad++;
      $display("FAIL basic_hold_after_sync got=%0d want=1", hold_seen);
    end
    total++;
    if (writes_match() !== 1'b1) begin
      bad++;
      $display("FAIL basic_writes got_n=%0d want_n=%0d", got_w.size(), exp_w.size());
    end
    total++;
    if (done_cnt != exp_done || err !== m_err || cpu_hold !== m_hold) begin
      bad++;
      $display("FAIL basic_status done=%0d/%0d err=%0d/%0d hold=%0d/%0d (got/want)",
               done_cnt, exp_done, err, m_err, cpu_hold, m_hold);
    end
  endtask

  task automatic test_bad_csum();
    frame = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
    send_frame();
    total++;
    if (writes_match() !== 1'b1 || done_cnt != 0 || err !== 1'b1 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL bad_csum writes=%0d done=%0d err=%0d hold=%0d want 3/0/1/1",
               got_w.size(), done_cnt, err, cpu_hold);
    end
    frame = '{8'hA5, 8'h00, 8'h02, 8'hF0, 8'h20, 8'h10};
    send_frame();
    total++;
    if (writes_match() !== 1'b1 || done_cnt != 1 || err !== 1'b0 || cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL recover_after_csum writes=%0d done=%0d err=%0d hold=%0d want 2/1/0/0",
               got_w.size(), done_cnt, err, cpu_hold);
    end
  endtask

  task automatic test_length();
    frame = '{8'hA5, 8'h04, 8'h01};
    send_frame();
    total++;
    if (got_w.size() != 0 || err !== 1'b1 || done_cnt != 0 || cpu_hold !== m_hold) begin
      bad++;
      $display("FAIL len_too_big writes=%0d err=%0d done=%0d hold=%0d want 0/1/0/%0d",
               got_w.size(), err, done_cnt, cpu_hold, m_hold);
    end
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    total++;
    if (got_w.size() != 0 || done_cnt != 1 || err !== 1'b0 || cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL len_zero writes=%0d done=%0d err=%0d hold=%0d want 0/1/0/0",
               got_w.size(), done_cnt, err, cpu_hold);
    end
  endtask

  task automatic test_frame_err();
    got_w.delete();
    done_cnt = 0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    total++;
    if (got_w.size() != 1 || got_w[0] !== {10'd0, 8'h11} || err !== 1'b1 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL frame_err writes=%0d err=%0d hold=%0d want 1/1/1",
               got_w.size(), err, cpu_hold);
    end
    // After the framing error the loader is back in IDLE, so a data byte is ignored.
    got_w.delete();
    send_byte(8'h33, 1'b0);
    repeat (20) @(negedge clk);
    total++;
    if (got_w.size() != 0 || done_cnt != 0 || err !== 1'b1) begin
      bad++;
      $display("FAIL frame_err_idle writes=%0d done=%0d err=%0d want 0/0/1",
               got_w.size(), done_cnt, err);
    end
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    total++;
    if (got_w.size() != 0 || done_cnt != 0 || err !== 1'b1 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL glitch writes=%0d done=%0d err=%0d hold=%0d want 0/0/1/1",
               got_w.size(), done_cnt, err, cpu_hold);
    end
    m_hold = 1'b1;
    m_err  = 1'b1;
  endtask

  task automatic test_reset_mid();
    got_w.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b0);
    rx = 1'b0;
    repeat (25) @(negedge clk);
    total++;
    if (got_w.size() != 2 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset writes=%0d hold=%0d want 2/1", got_w.size(), cpu_hold);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !== 22'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {mem_we, mem_addr, mem_wdata, cpu_hold, done, err});
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n  = 1'b1;
    m_hold = 1'b0;
    m_err  = 1'b0;
    repeat (30) @(negedge clk);
    frame = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_frame();
    total++;
    if (writes_match() !== 1'b1 || done_cnt != 1 || err !== 1'b0 || cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL after_reset writes=%0d done=%0d err=%0d hold=%0d want 4/1/0/0",
               got_w.size(), done_cnt, err, cpu_hold);
    end
  endtask

  task automatic test_random();
    int unsigned n;
    int unsigned sum;
    int unsigned mode;
    for (int f = 0; f < 10; f++) begin
      frame.delete();
      mode = $urandom_range(0, 3);
      frame.push_back(8'hA5);
      if (mode == 3) begin
        n = $urandom_range(1025, 65535);
        frame.push_back(n[15:8]);
        frame.push_back(n[7:0]);
      end else begin
        n = $urandom_range(1, 12);
        frame.push_back(8'h00);
        frame.push_back(n[7:0]);
        sum = 0;
        for (int i = 0; i < int'(n); i++) begin
          frame.push_back(8'($urandom));
          sum = sum + frame[frame.size()-1];
        end
        if (mode == 2) sum = sum + $urandom_range(1, 255);
        frame.push_back(sum[7:0]);
      end
      send_frame();
      total++;
      if (writes_match() !== 1'b1 || done_cnt != exp_done || err !== m_err || cpu_hold !== m_hold) begin
        bad++;
        $display("FAIL random_frame%0d n=%0d writes=%0d/%0d done=%0d/%0d err=%0d/%0d hold=%0d/%0d (got/want)",
                 f, n, got_w.size(), exp_w.size(), done_cnt, exp_done, err, m_err, cpu_hold, m_hold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_length();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu7_prog_loader.md
# cpu7_prog_loader

Serial program loader for the cpu7 SoC: receives a framed program image over a UART RX line (8N1), writes it byte-by-byte into program memory, and holds the cores halted while the load is in progress. It is the receiving end of the host-side image sender. It sits between the board RX pin and the program-memory write port of `cpu7_soc`, and replaces `INIT_F` preloading on hardware.

## Interface
Parameters
- `CLOCK_FREQ_MHZ`, 1: system clock in MHz.
- `BAUD_RATE`, 100000: UART bit rate. `CLKS_PER_BIT = CLOCK_FREQ_MHZ*1_000_000/BAUD_RATE`, integer, must be ≥ 4.
- `PROGRAM_SIZE`, 1024: program memory depth in bytes. `AW = $clog2(PROGRAM_SIZE)`.

Ports
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART line, idle high, asynchronous to `clk`.
- `mem_we`  out  1  program memory write strobe, one-cycle pulse per byte.
- `mem_addr`  out  AW  write address.
- `mem_wdata`  out  8  write data.
- `cpu_hold`  out  1  keeps the cores halted while high.
- `done`  out  1  one-cycle pulse on successful load.
- `err`  out  1  sticky error flag.

## Operation
- RX front end: `rx` is synchronised through 2 FFs. A falling edge in IDLE starts a bit timer. The start bit is re-sampled at `CLKS_PER_BIT/2`; if it is high, the event is a glitch and the receiver returns to IDLE. Eight data bits follow, LSB first, each sampled at bit centre. The stop bit is sampled at its centre: 1 gives `byte_valid` for one cycle; 0 is a framing error.
- Frame: `0xA5` sync, `LEN_HI`, `LEN_LO` (byte count N, 16-bit), N data bytes, then `CSUM` = 8-bit sum mod 256 of the data bytes.
- Loader FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM.
  - IDLE: ignores any byte other than `0xA5`. On `0xA5`: clear `err`, assert `cpu_hold`, go to LEN_HI.
  - LEN_HI → LEN_LO on the next byte.
  - After LEN_LO:
    - N > `PROGRAM_SIZE`: `err`=1, go to IDLE.
    - N = 0: go to CSUM.
    - Otherwise: clear the address counter and accumulator, go to DATA.
  - DATA: each byte is written to `mem_addr` = count, then count increments and the byte is added to the accumulator. After the Nth byte, go to CSUM.
  - CSUM: byte equals the accumulator → `done` pulse, `cpu_hold`=0, go to IDLE. Mismatch → `err`=1, `cpu_hold` stays 1, go to IDLE.
- A framing error in any non-IDLE state sets `err`=1 and returns the FSM to IDLE with `cpu_hold` unchanged. A framing error while in IDLE is ignored.
- After any error, the cores stay halted until a subsequent load succeeds.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `done`=0, `err`=0. The RX state is idle and the FSM is in IDLE.
- Reset asserted mid-frame aborts immediately. After release, the loader waits for a fresh sync byte.
- Synchroniser latency is 2 cycles. `byte_valid` fires at the stop-bit centre.
- `mem_we`, `mem_addr` and `mem_wdata` are registered and valid in the cycle after `byte_valid`.
- `cpu_hold` rises in the cycle after the sync byte's `byte_valid`.
- `done` and the fall of `cpu_hold` both occur in the cycle after the CSUM `byte_valid`. `err` sets on that same edge for a mismatch.
- The receiver re-arms on the first cycle after the stop-bit centre, so back-to-back bytes with a 1-bit stop are accepted.
- Address counter is AW bits and never wraps: N ≤ `PROGRAM_SIZE` guarantees the last address is N−1.
- Accumulator is 8-bit and wraps mod 256.

## Test plan
All scenarios use `CLOCK_FREQ_MHZ`=1, `BAUD_RATE`=100000 (10 clocks/bit), `PROGRAM_SIZE`=1024.
- Reset then idle line: all outputs 0 for 1000 cycles. Any byte other than `0xA5` (e.g. `0x3C`) causes no output change.
- Frame `A5 00 03 11 22 33 66`: writes `0x11`@0, `0x22`@1, `0x33`@2. `cpu_hold` is high from the sync byte until the checksum. Exactly one `done` pulse. `err`=0.
- Same frame with checksum `0x67`: three writes occur, no `done`, `err`=1, `cpu_hold` stays 1. A following valid frame clears `err`, pulses `done`, and drops `cpu_hold`.
- Frame `A5 04 01 …` (N=1025): `err`=1, no `mem_we` pulses. Frame `A5 00 00 00` (N=0): `done` pulse, zero writes.
- Stop bit forced low during the second data byte: `err`=1, only the first byte is written, FSM returns to IDLE. A 3-cycle low glitch on `rx` in IDLE produces no byte.
- `rst_n` pulsed low mid-DATA: outputs return to 0 immediately. A full valid frame sent afterwards loads correctly from address 0.
